store_seq_checker: RTL and testbench
====================================

Name: store_seq_checker

Overview:
- Synthesizable, parametrised checker for the RV32I single-cycle core's data-memory write port; sits beside `top` and observes MemWrite/DataAdr/WriteData.
- Generalises the old single "address 100 = 25" check: an in-order sequence of NUM_CHECKS expected (address, data) stores, a configurable ignore window, a cycle timeout, and latched diagnostics.
- Results are registered outputs, so benches and FPGA builds use the same block.

Parameters:
- NUM_CHECKS, 1: number of expected stores, matched in order.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- IGNORE_BASE, 96: first byte address of the ignored-store window.
- IGNORE_SIZE, 4: window length in bytes; 0 disables the window.
- TIMEOUT_CYCLES, 1000: RUN cycles allowed before TIMEOUT; 0 disables the timeout.
- CNT_W, 16: width of the store and cycle counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; leaves IDLE.
- clear  in  1  returns to IDLE from any state; clears counters and diagnostics.
- mem_write  in  1  store strobe from the core.
- data_adr  in  ADDR_W  store address.
- write_data  in  DATA_W  store data.
- exp_addr  in  NUM_CHECKS*ADDR_W  expected addresses; entry i is bits [i*ADDR_W +: ADDR_W].
- exp_data  in  NUM_CHECKS*DATA_W  expected data, same packing.
- done  out  1  high in PASS, FAIL or TIMEOUT.
- pass  out  1  all checks matched in order.
- fail  out  1  unexpected store seen.
- timeout  out  1  timeout expired.
- match_idx  out  $clog2(NUM_CHECKS+1)  number of checks matched so far.
- store_cnt  out  CNT_W  stores observed in RUN; saturating.
- ignored_cnt  out  CNT_W  stores that fell in the ignore window; saturating.
- fail_addr  out  ADDR_W  address of the offending store.
- fail_data  out  DATA_W  data of the offending store.

Behaviour:
- Reset (asynchronous, active-high) and clear (synchronous): state=IDLE; all outputs, counters and fail_* are 0.
- clear has priority over start and mem_write.
- States: IDLE, RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal and hold until clear or reset.
- IDLE -> RUN on start. mem_write is ignored in IDLE, including in the start cycle.
- In RUN, each cycle with mem_write=1 increments store_cnt. The store is then classified in this priority order:
  1. data_adr == exp_addr[match_idx] and write_data == exp_data[match_idx]: match_idx+1. If the new value equals NUM_CHECKS, go to PASS on the same edge.
  2. IGNORE_SIZE != 0 and IGNORE_BASE <= data_adr < IGNORE_BASE+IGNORE_SIZE: ignored_cnt+1; no state change.
  3. Otherwise: go to FAIL and latch fail_addr/fail_data. match_idx holds, identifying the failing check.
- A correct address with wrong data is a FAIL, unless that address also lies in the ignore window.
- Timeout: a cycle counter runs only in RUN. On the edge it reaches TIMEOUT_CYCLES, the FSM goes to TIMEOUT.
- A store decision on the timeout edge takes priority: a completing match gives PASS and a mismatch gives FAIL.
- Latency: flags assert on the edge that samples the deciding store; done = pass|fail|timeout, registered.
- Counters saturate at all-ones and never wrap.
- Stores in terminal states are not counted.
- start in RUN or in a terminal state has no effect.
- Reset mid-RUN aborts immediately to IDLE with all outputs 0.

Optional Feature:
- Macro STORE_SEQ_CHECKER_TRACE_EN. When defined, adds a trace FIFO of depth 8 recording every store seen in RUN (address and data).
- Extra ports: trace_rd (in, 1), trace_valid (out, 1), trace_addr (out, ADDR_W), trace_data (out, DATA_W), trace_ovf (out, 1).
- trace_valid is high when the FIFO is not empty; the head is presented on trace_addr/trace_data.
- trace_rd pops the head when trace_valid is high and is ignored when empty.
- Full-FIFO store: entry dropped and trace_ovf set sticky. A simultaneous push and pop when full is accepted.
- Reset and clear empty the FIFO and clear trace_ovf.
- Without the macro: ports and logic are absent; all other behaviour is identical.

Test Plan:
- NUM_CHECKS=1, exp (100,25). Sequence: start, store (96,7), then store (100,25) -> ignored_cnt=1, store_cnt=2, pass=1 and done=1 on the second store's edge, fail=0.
- Same config, store (104,25) -> fail=1, fail_addr=104, fail_data=25, match_idx=0; a later store (100,25) leaves fail=1 and store_cnt=1.
- NUM_CHECKS=3, exp (100,25),(104,3),(108,9). Stores (104,3),(100,25) -> fail on the first store, match_idx=0. After clear, start, then the correct order -> pass, match_idx=3.
- TIMEOUT_CYCLES=20, start, no stores -> timeout=1 exactly 20 edges after RUN entry. The matching store on that edge gives pass instead.
- Assert reset mid-RUN after 1 match -> all outputs 0 asynchronously; start with mem_write=1 in the same cycle -> store_cnt stays 0.
- TRACE_EN defined: 9 stores with no reads -> trace_ovf=1. Reads return the first 8 entries in order, then trace_valid=0.

Source files
------------

// File: rtl/store_seq_checker.sv
// -----------------------------------------------------------------------------
// store_seq_checker
//   Watches the data-memory write port of the RV32I single-cycle core and
//   checks that an ordered list of expected (address, data) stores occurs.
//   Stores inside a configurable byte window are tolerated and counted.
//   A RUN-cycle timeout and latched failure diagnostics are provided.
//   All results are registered.
//
// Optional feature (macro STORE_SEQ_CHECKER_TRACE_EN):
//   This macro adds an 8-deep trace FIFO. The FIFO records every store seen
//   in RUN.
//
// Ports:
//   clk, reset (async, active-high), start, clear (sync, highest priority)
//   mem_write, data_adr, write_data  : observed store port
//   exp_addr, exp_data               : packed expected list, entry i at [i*W +: W]
//   done, pass, fail, timeout        : verdict flags
//   match_idx                        : checks matched so far
//   store_cnt, ignored_cnt           : saturating store counters
//   fail_addr, fail_data             : offending store
//   trace_rd/valid/addr/data/ovf     : trace FIFO (only with the macro)
// -----------------------------------------------------------------------------
module store_seq_checker #(
  parameter int NUM_CHECKS     = 1,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int IGNORE_BASE    = 96,
  parameter int IGNORE_SIZE    = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           clear,
  input  logic                           mem_write,
  input  logic [ADDR_W-1:0]              data_adr,
  input  logic [DATA_W-1:0]              write_data,
  input  logic [NUM_CHECKS*ADDR_W-1:0]   exp_addr,
  input  logic [NUM_CHECKS*DATA_W-1:0]   exp_data,
  output logic                           done,
  output logic                           pass,
  output logic                           fail,
  output logic                           timeout,
  output logic [$clog2(NUM_CHECKS+1)-1:0] match_idx,
  output logic [CNT_W-1:0]               store_cnt,
  output logic [CNT_W-1:0]               ignored_cnt,
  output logic [ADDR_W-1:0]              fail_addr,
  output logic [DATA_W-1:0]              fail_data
`ifdef STORE_SEQ_CHECKER_TRACE_EN
  ,
  input  logic                           trace_rd,
  output logic                           trace_valid,
  output logic [ADDR_W-1:0]              trace_addr,
  output logic [DATA_W-1:0]              trace_data,
  output logic                           trace_ovf
`endif
);

  localparam int MW = $clog2(NUM_CHECKS+1);
  // Window bounds carry one extra bit so BASE+SIZE cannot wrap.
  localparam logic [ADDR_W:0] IGN_LO = (ADDR_W+1)'(IGNORE_BASE);
  localparam logic [ADDR_W:0] IGN_HI = IGN_LO + (ADDR_W+1)'(IGNORE_SIZE);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cyc;

  logic [ADDR_W-1:0] w_exp_addr;
  logic [DATA_W-1:0] w_exp_data;
  logic [MW-1:0]     w_match_next;
  logic [CNT_W-1:0]  w_cyc_next;
  logic              w_match, w_in_window, w_complete, w_tmo, w_store;
  logic              w_go_pass, w_go_fail, w_go_tmo;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + CNT_W'(1);
  endfunction

  // Select the expected entry addressed by match_idx (OR of one-hot terms).
  always_comb begin
    w_exp_addr = '0;
    w_exp_data = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      w_exp_addr = w_exp_addr | ((match_idx == MW'(i)) ? exp_addr[i*ADDR_W +: ADDR_W] : '0);
      w_exp_data = w_exp_data | ((match_idx == MW'(i)) ? exp_data[i*DATA_W +: DATA_W] : '0);
    end
  end

  assign w_match      = (data_adr == w_exp_addr) && (write_data == w_exp_data);
  assign w_in_window  = (IGNORE_SIZE != 0) && ({1'b0, data_adr} >= IGN_LO) &&
                        ({1'b0, data_adr} < IGN_HI);
  assign w_match_next = match_idx + MW'(1);
  assign w_complete   = (w_match_next == MW'(NUM_CHECKS));
  assign w_cyc_next   = sat_inc(r_cyc);
  assign w_tmo        = (TIMEOUT_CYCLES != 0) && (32'(w_cyc_next) == 32'(TIMEOUT_CYCLES));
  assign w_store      = (r_state == S_RUN) && mem_write;
  // A store decided on the timeout edge overrides the timeout.
  assign w_go_pass    = w_store && w_match && w_complete;
  assign w_go_fail    = w_store && !w_match && !w_in_window;
  assign w_go_tmo     = (r_state == S_RUN) && w_tmo && !w_go_pass && !w_go_fail;

  // Checker FSM with registered verdicts, counters and diagnostics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cyc       <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      match_idx   <= '0;
      store_cnt   <= '0;
      ignored_cnt <= '0;
      fail_addr   <= '0;
      fail_data   <= '0;
    end else if (clear) begin
      r_state     <= S_IDLE;
      r_cyc       <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      match_idx   <= '0;
      store_cnt   <= '0;
      ignored_cnt <= '0;
      fail_addr   <= '0;
      fail_data   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_RUN;
          else       r_state <= S_IDLE;
        end
        S_RUN: begin
          r_cyc <= w_cyc_next;
          if (mem_write) store_cnt <= sat_inc(store_cnt);
          else           store_cnt <= store_cnt;
          if (w_store && w_match) match_idx <= w_match_next;
          else                    match_idx <= match_idx;
          if (w_store && !w_match && w_in_window) ignored_cnt <= sat_inc(ignored_cnt);
          else                                    ignored_cnt <= ignored_cnt;
          if (w_go_pass) begin
            r_state <= S_PASS;
            pass    <= 1'b1;
            done    <= 1'b1;
          end else if (w_go_fail) begin
            r_state   <= S_FAIL;
            fail      <= 1'b1;
            done      <= 1'b1;
            fail_addr <= data_adr;
            fail_data <= write_data;
          end else if (w_go_tmo) begin
            r_state <= S_TIMEOUT;
            timeout <= 1'b1;
            done    <= 1'b1;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_PASS, S_FAIL, S_TIMEOUT: r_state <= r_state;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef STORE_SEQ_CHECKER_TRACE_EN
  logic [ADDR_W-1:0] r_tr_addr [8];
  logic [DATA_W-1:0] r_tr_data [8];
  logic [2:0]        r_wr_ptr, r_rd_ptr;
  logic [3:0]        r_tr_cnt;
  logic              r_tr_ovf;
  logic              w_tr_pop, w_tr_full, w_tr_accept;

  assign w_tr_pop    = trace_rd && (r_tr_cnt != 4'd0);
  assign w_tr_full   = (r_tr_cnt == 4'd8);
  // When full, a push is accepted only if a pop frees a slot on the same edge.
  assign w_tr_accept = w_store && (!w_tr_full || w_tr_pop);

  // Trace FIFO storage, pointers and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        r_tr_addr[i] <= '0;
        r_tr_data[i] <= '0;
      end
      r_wr_ptr <= 3'd0;
      r_rd_ptr <= 3'd0;
      r_tr_cnt <= 4'd0;
      r_tr_ovf <= 1'b0;
    end else if (clear) begin
      r_wr_ptr <= 3'd0;
      r_rd_ptr <= 3'd0;
      r_tr_cnt <= 4'd0;
      r_tr_ovf <= 1'b0;
    end else begin
      if (w_tr_accept) begin
        r_tr_addr[r_wr_ptr] <= data_adr;
        r_tr_data[r_wr_ptr] <= write_data;
        r_wr_ptr            <= r_wr_ptr + 3'd1;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_tr_pop) r_rd_ptr <= r_rd_ptr + 3'd1;
      else          r_rd_ptr <= r_rd_ptr;
      case ({w_tr_accept, w_tr_pop})
        2'b10:   r_tr_cnt <= r_tr_cnt + 4'd1;
        2'b01:   r_tr_cnt <= r_tr_cnt - 4'd1;
        default: r_tr_cnt <= r_tr_cnt;
      endcase
      if (w_store && !w_tr_accept) r_tr_ovf <= 1'b1;
      else                         r_tr_ovf <= r_tr_ovf;
    end
  end

  assign trace_valid = (r_tr_cnt != 4'd0);
  assign trace_addr  = r_tr_addr[r_rd_ptr];
  assign trace_data  = r_tr_data[r_rd_ptr];
  assign trace_ovf   = r_tr_ovf;
`endif

endmodule

// File: tb/tb_store_seq_checker.sv
module tb_store_seq_checker;

  logic        clk = 1'b0;
  logic        reset, start, clear, mem_write;
  logic [31:0] data_adr, write_data;
  logic        trace_rd;

  always #5 clk = ~clk;

  // Per-instance observed outputs: 0 = one check, 1 = three checks, 2 = timeout 20
  logic        done_v [3], pass_v [3], fail_v [3], tmo_v [3];
  logic [15:0] scnt_v [3], icnt_v [3];
  logic [31:0] faddr_v [3], fdata_v [3];
  logic [0:0]  m_u1, m_ut;
  logic [1:0]  m_u3;
  logic        tv_v [3], to_v [3];
  logic [31:0] ta_v [3], td_v [3];

  store_seq_checker #(.NUM_CHECKS(1)) u1 (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .mem_write(mem_write),
    .data_adr(data_adr), .write_data(write_data),
    .exp_addr(32'd100), .exp_data(32'd25),
    .done(done_v[0]), .pass(pass_v[0]), .fail(fail_v[0]), .timeout(tmo_v[0]),
    .match_idx(m_u1), .store_cnt(scnt_v[0]), .ignored_cnt(icnt_v[0]),
    .fail_addr(faddr_v[0]), .fail_data(fdata_v[0])
`ifdef STORE_SEQ_CHECKER_TRACE_EN
    , .trace_rd(trace_rd), .trace_valid(tv_v[0]), .trace_addr(ta_v[0]),
    .trace_data(td_v[0]), .trace_ovf(to_v[0])
`endif
  );

  store_seq_checker #(.NUM_CHECKS(3)) u3 (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .mem_write(mem_write),
    .data_adr(data_adr), .write_data(write_data),
    .exp_addr({32'd108, 32'd104, 32'd100}), .exp_data({32'd9, 32'd3, 32'd25}),
    .done(done_v[1]), .pass(pass_v[1]), .fail(fail_v[1]), .timeout(tmo_v[1]),
    .match_idx(m_u3), .store_cnt(scnt_v[1]), .ignored_cnt(icnt_v[1]),
    .fail_addr(faddr_v[1]), .fail_data(fdata_v[1])
`ifdef STORE_SEQ_CHECKER_TRACE_EN
    , .trace_rd(trace_rd), .trace_valid(tv_v[1]), .trace_addr(ta_v[1]),
    .trace_data(td_v[1]), .trace_ovf(to_v[1])
`endif
  );

  store_seq_checker #(.NUM_CHECKS(1), .TIMEOUT_CYCLES(20)) ut (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .mem_write(mem_write),
    .data_adr(data_adr), .write_data(write_data),
    .exp_addr(32'd100), .exp_data(32'd25),
    .done(done_v[2]), .pass(pass_v[2]), .fail(fail_v[2]), .timeout(tmo_v[2]),
    .match_idx(m_ut), .store_cnt(scnt_v[2]), .ignored_cnt(icnt_v[2]),
    .fail_addr(faddr_v[2]), .fail_data(fdata_v[2])
`ifdef STORE_SEQ_CHECKER_TRACE_EN
    , .trace_rd(trace_rd), .trace_valid(tv_v[2]), .trace_addr(ta_v[2]),
    .trace_data(td_v[2]), .trace_ovf(to_v[2])
`endif
  );

  typedef struct packed {
    logic        p, f, t;
    logic [31:0] m, s, i, a, d;
  } exp_t;

  exp_t  sb_q [$];
  string tag_q [$];
  int    sel;
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input bit p, f, t, input int m, s, i, a, d);
    exp_t e;
    e.p = p; e.f = f; e.t = t;
    e.m = 32'(m); e.s = 32'(s); e.i = 32'(i); e.a = 32'(a); e.d = 32'(d);
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Pop the oldest expectation and compare it with the selected instance.
  task automatic compare_head();
    exp_t        e;
    string       t;
    logic [31:0] m;
    if (sb_q.size() == 0) begin
      check_eq("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      m = (sel == 1) ? 32'(m_u3) : (sel == 0) ? 32'(m_u1) : 32'(m_ut);
      check_eq({t, ".pass"},      64'(pass_v[sel]),  64'(e.p));
      check_eq({t, ".fail"},      64'(fail_v[sel]),  64'(e.f));
      check_eq({t, ".timeout"},   64'(tmo_v[sel]),   64'(e.t));
      check_eq({t, ".done"},      64'(done_v[sel]),  64'(e.p | e.f | e.t));
      check_eq({t, ".match_idx"}, 64'(m),            64'(e.m));
      check_eq({t, ".store_cnt"}, 64'(scnt_v[sel]),  64'(e.s));
      check_eq({t, ".ign_cnt"},   64'(icnt_v[sel]),  64'(e.i));
      check_eq({t, ".fail_addr"}, 64'(faddr_v[sel]), 64'(e.a));
      check_eq({t, ".fail_data"}, 64'(fdata_v[sel]), 64'(e.d));
    end
  endtask

  task automatic drive(input bit st, cl, mw, input int a, d);
    @(negedge clk);
    start = st; clear = cl; mem_write = mw;
    data_adr = 32'(a); write_data = 32'(d);
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of stimulus, queue its expectation, check after the edge.
  task automatic sb_step(input string tag, input bit st, cl, mw, input int a, d,
                         input bit p, f, t, input int m, s, i, fa, fd);
    push_exp(tag, p, f, t, m, s, i, fa, fd);
    drive(st, cl, mw, a, d);
    compare_head();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; clear = 1'b0; mem_write = 1'b0;
    data_adr = 32'd0; write_data = 32'd0; trace_rd = 1'b0;
    sel = 0;
    repeat (2) @(posedge clk);
    #1;
    push_exp("reset", 0,0,0, 0,0,0,0,0);
    compare_head();
    @(negedge clk);
    reset = 1'b0;

    // One check: ignored store then matching store
    sel = 0;
    sb_step("t1.clear", 0,1,0,   0, 0, 0,0,0, 0,0,0,0,0);
    sb_step("t1.start", 1,0,0,   0, 0, 0,0,0, 0,0,0,0,0);
    sb_step("t1.ign",   0,0,1,  96, 7, 0,0,0, 0,1,1,0,0);
    sb_step("t1.match", 0,0,1, 100,25, 1,0,0, 1,2,1,0,0);
    sb_step("t1.after", 0,0,1, 100,25, 1,0,0, 1,2,1,0,0);
    sb_step("t1.start2",1,0,0,   0, 0, 1,0,0, 1,2,1,0,0);

    // One check: wrong address fails and latches diagnostics
    sb_step("t2.clear", 0,1,0,   0, 0, 0,0,0, 0,0,0,0,0);
    sb_step("t2.start", 1,0,0,   0, 0, 0,0,0, 0,0,0,0,0);
    sb_step("t2.bad",   0,0,1, 104,25, 0,1,0, 0,1,0,104,25);
    sb_step("t2.late",  0,0,1, 100,25, 0,1,0, 0,1,0,104,25);

    // Right address, wrong data
    sb_step("t2b.clear",0,1,0,   0, 0, 0,0,0, 0,0,0,0,0);
    sb_step("t2b.start",1,0,0,   0, 0, 0,0,0, 0,0,0,0,0);
    sb_step("t2b.data", 0,0,1, 100,26, 0,1,0, 0,1,0,100,26);

    // Three checks: out-of-order then in-order
    sel = 1;
    sb_step("t3.clear", 0,1,0,   0, 0, 0,0,0, 0,0,0,0,0);
    sb_step("t3.start", 1,0,0,   0, 0, 0,0,0, 0,0,0,0,0);
    sb_step("t3.ooo",   0,0,1, 104, 3, 0,1,0, 0,1,0,104,3);
    sb_step("t3.late",  0,0,1, 100,25, 0,1,0, 0,1,0,104,3);
    sb_step("t3.clr2",  0,1,0,   0, 0, 0,0,0, 0,0,0,0,0);
    sb_step("t3.st2",   1,0,0,   0, 0, 0,0,0, 0,0,0,0,0);
    sb_step("t3.m0",    0,0,1, 100,25, 0,0,0, 1,1,0,0,0);
    sb_step("t3.idle",  0,0,0,   0, 0, 0,0,0, 1,1,0,0,0);
    sb_step("t3.m1",    0,0,1, 104, 3, 0,0,0, 2,2,0,0,0);
    sb_step("t3.m2",    0,0,1, 108, 9, 1,0,0, 3,3,0,0,0);

    // Timeout after exactly 20 RUN edges
    sel = 2;
    sb_step("t4.clear", 0,1,0, 0,0, 0,0,0, 0,0,0,0,0);
    sb_step("t4.start", 1,0,0, 0,0, 0,0,0, 0,0,0,0,0);
    for (int k = 1; k < 20; k++)
      sb_step("t4.wait", 0,0,0, 0,0, 0,0,0, 0,0,0,0,0);
    sb_step("t4.tmo",   0,0,0, 0,0, 0,0,1, 0,0,0,0,0);
    sb_step("t4.hold",  1,0,1, 100,25, 0,0,1, 0,0,0,0,0);

    // Matching store on the timeout edge wins
    sb_step("t4b.clear",0,1,0, 0,0, 0,0,0, 0,0,0,0,0);
    sb_step("t4b.start",1,0,0, 0,0, 0,0,0, 0,0,0,0,0);
    for (int k = 1; k < 20; k++)
      sb_step("t4b.wait", 0,0,0, 0,0, 0,0,0, 0,0,0,0,0);
    sb_step("t4b.pass", 0,0,1, 100,25, 1,0,0, 1,1,0,0,0);

    // Asynchronous reset mid-RUN, then start with a store in the same cycle
    sel = 1;
    sb_step("t5.clear", 0,1,0,   0, 0, 0,0,0, 0,0,0,0,0);
    sb_step("t5.start", 1,0,0,   0, 0, 0,0,0, 0,0,0,0,0);
    sb_step("t5.m0",    0,0,1, 100,25, 0,0,0, 1,1,0,0,0);
    @(negedge clk);
    mem_write = 1'b0;
    reset = 1'b1;
    #1;
    push_exp("t5.async", 0,0,0, 0,0,0,0,0);
    compare_head();
    @(negedge clk);
    reset = 1'b0;
    sb_step("t5.stw",   1,0,1, 100,25, 0,0,0, 0,0,0,0,0);
    sb_step("t5.m0b",   0,0,1, 100,25, 0,0,0, 1,1,0,0,0);

`ifdef STORE_SEQ_CHECKER_TRACE_EN
    // Trace FIFO: nine ignored stores overflow an 8-deep FIFO
    sel = 0;
    sb_step("t6.clear", 0,1,0, 0,0, 0,0,0, 0,0,0,0,0);
    sb_step("t6.start", 1,0,0, 0,0, 0,0,0, 0,0,0,0,0);
    for (int k = 0; k < 9; k++)
      sb_step("t6.st", 0,0,1, 96 + (k % 4), k, 0,0,0, 0,k+1,k+1,0,0);
    drive(0,0,0, 0,0);
    check_eq("t6.ovf",   64'(to_v[0]), 64'd1);
    check_eq("t6.valid", 64'(tv_v[0]), 64'd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      trace_rd = 1'b1;
      #1;
      check_eq("t6.rd_valid", 64'(tv_v[0]), 64'd1);
      check_eq("t6.rd_addr",  64'(ta_v[0]), 64'(96 + (k % 4)));
      check_eq("t6.rd_data",  64'(td_v[0]), 64'(k));
    end
    @(negedge clk);
    trace_rd = 1'b0;
    #1;
    check_eq("t6.empty", 64'(tv_v[0]), 64'd0);
    check_eq("t6.ovf_sticky", 64'(to_v[0]), 64'd1);
    sb_step("t6.clr2", 0,1,0, 0,0, 0,0,0, 0,0,0,0,0);
    check_eq("t6.ovf_clr", 64'(to_v[0]), 64'd0);
`endif

    if (sb_q.size() != 0) check_eq("scoreboard_left", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
